int_ctrl: RTL and testbench
===========================

// Module: int_ctrl
// PURPOSE
//   16-line external interrupt controller that feeds the rv32 CPU core.
//   - Synchronises asynchronous INT lines and latches each rising edge as pending.
//   - Picks the highest-priority pending line that the CPU has enabled.
//   - Presents it to the CPU as a one-cycle IRQ pulse with its line number on IRQnum.
//   Sits between board/peripheral interrupt sources and the CPU IRQ/IRQnum/IRQen ports.
// PARAMETERS
//   SYNC_STAGES  2   flops in each INT input synchroniser (legal values >= 2)
// PORTS
//   clk     in   1   system clock; all state updates on the rising edge
//   rst     in   1   reset; one clock, reset asynchronous and active-low (rst=0 resets)
//   INT     in   16  raw interrupt request lines, asynchronous to clk; a rising edge requests service
//   IRQen   in   16  per-line enable mask from the CPU; bit i=1 allows line i to be signalled
//   IRQ     out  1   registered one-cycle interrupt pulse to the CPU
//   IRQnum  out  4   registered number of the line being signalled; valid while IRQ=1
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//   - Clears synchroniser flops, edge-history flops and pending[15:0].
//   - Forces IRQ=0, IRQnum=0 and state=IDLE. Outputs hold these values until the first clk edge after rst=1.
//   - Reset mid-pulse drops IRQ immediately and discards all pending requests.
//   Input path, per line i:
//   - INT[i] passes through SYNC_STAGES flops giving s[i].
//   - Edge-history flop h[i] <= s[i]; rise[i] = s[i] & ~h[i].
//   - A line held high across reset release therefore produces exactly one request.
//   Pending:
//   - pending[i] sets on rise[i] and clears only when line i is fired.
//   - If a set and a clear of the same bit happen in the same cycle, the set wins: the bit stays 1.
//   - Extra edges while already pending merge; there is no counting.
//   - Disabled lines (IRQen[i]=0) stay pending and fire once they are enabled.
//   Selection:
//   - cand = pending & IRQen.
//   - sel = lowest-index set bit of cand; line 0 is the highest priority. The encoder is fixed priority, not round-robin.
//   FSM, 3 states:
//   - IDLE: if cand!=0, register IRQ<=1, IRQnum<=sel, clear pending[sel], go to FIRE. Otherwise IRQ<=0.
//   - FIRE: IRQ is high for exactly this one cycle. Next edge: IRQ<=0, go to GAP.
//   - GAP: IRQ stays 0 for one cycle, then go to IDLE. This guarantees back-to-back interrupts are separated by at least 1 low cycle.
//   - IRQnum holds its last value when IRQ=0.
//   - IRQen is sampled only in IDLE. Clearing an enable during FIRE does not cancel the pulse in progress.
//   Latency (SYNC_STAGES=2):
//   - Edge E0 is the first rising edge that samples INT[i]=1. pending[i] sets at E2 and IRQ rises at E3.
//   - IRQ is high during cycle E3..E4.
//   - Minimum INT high time is 1 clk period plus setup. Shorter glitches may be missed.
//   Simultaneous events:
//   - Several lines rising together are serviced in ascending index order.
//   - Each service takes 3 cycles (IDLE->FIRE->GAP).
// TESTING
//   - Reset: drive rst=0 with INT=16'hFFFF -> IRQ=0, IRQnum=0 immediately.
//     Release rst with IRQen=16'hFFFF -> 16 pulses, IRQnum 0..15 in order, each 3 cycles apart.
//   - Single line: IRQen=16'h0001, INT[0] high for 2 clks -> exactly one IRQ pulse, 1 cycle wide, IRQnum=0, rising at E3.
//   - Priority: INT[5] and INT[2] rise on the same edge with IRQen=16'hFFFF
//     -> pulse with IRQnum=2, IRQ low for 2 cycles, then pulse with IRQnum=5.
//   - Masking: IRQen=0, pulse INT[1] -> no IRQ for 20 cycles.
//     Then set IRQen=16'h0002 -> one pulse, IRQnum=1, exactly 1 cycle after IRQen rises.
//   - Merge/re-arm:
//     - Pulse INT[3] twice while masked, then enable it -> one pulse only.
//     - Pulse INT[3] again after service -> a second pulse.
//   - Async reset mid-pulse: assert rst=0 while IRQ=1 -> IRQ=0 without waiting for clk.
//     No pulse after release unless a new edge arrives.

Source files
------------

// File: rtl/int_ctrl.sv
// 16-line external interrupt controller: synchronises INT lines, latches rising
// edges as pending and presents the highest-priority enabled one as an IRQ pulse.
module int_ctrl #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] INT,
   input  logic [15:0] IRQen,
   output logic        IRQ,
   output logic [3:0]  IRQnum
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      GAP  = 2'd2
   } state_t;

   logic [15:0] sync_q [SYNC_STAGES];
   logic [15:0] hist_q;
   logic [15:0] pend_q, pend_d;
   logic [15:0] s, rise, cand, clr;
   logic [3:0]  sel;
   logic        found, fire;
   state_t      state_q;
   logic        irq_q;
   logic [3:0]  irqnum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         hist_q <= '0;
      end else begin
         sync_q[0] <= INT;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         hist_q <= s;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~hist_q;
   assign cand = pend_q & IRQen;

   // Fixed-priority encoder: lowest set index of cand wins.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (cand[i] && !found) begin
            sel   = 4'(i);
            found = 1'b1;
         end
      end
   end

   assign fire = (state_q == IDLE) && found;
   assign clr  = fire ? (16'd1 << sel) : '0;

   // A new edge on the line being fired must survive, so set is applied after clear.
   assign pend_d = (pend_q & ~clr) | rise;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pend_q <= '0;
      else      pend_q <= pend_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         irq_q    <= 1'b0;
         irqnum_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fire) begin
                  irq_q    <= 1'b1;
                  irqnum_q <= sel;
                  state_q  <= FIRE;
               end else begin
                  irq_q <= 1'b0;
               end
            end
            FIRE: begin
               irq_q   <= 1'b0;
               state_q <= GAP;
            end
            GAP: begin
               irq_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               irq_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign IRQ    = irq_q;
   assign IRQnum = irqnum_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expected pulses (line number and cycle) are queued
// when stimulus is driven and checked whenever the DUT raises IRQ.
module tb_int_ctrl;

   typedef struct {
      logic [3:0]  num;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] INT;
   logic [15:0] IRQen;
   logic        IRQ;
   logic [3:0]  IRQnum;

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   exp_t        sb[$];

   int_ctrl #(.SYNC_STAGES(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .INT    (INT),
      .IRQen  (IRQen),
      .IRQ    (IRQ),
      .IRQnum (IRQnum)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && IRQ === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_irq", 32'(IRQ), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("irqnum", 32'(IRQnum), 32'(e.num));
            chk("irq_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic push(input logic [3:0] num, input int unsigned c);
      exp_t e;
      e.num = num;
      e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input string tag, input int unsigned budget);
      int unsigned n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      chk(tag, sb.size(), 32'd0);
   endtask

   task automatic pulse_int(input logic [15:0] mask, input int unsigned hi);
      INT = mask;
      repeat (hi) @(negedge clk);
      INT = '0;
   endtask

   initial begin
      int unsigned c;

      // Reset with all lines high
      rst   = 1'b0;
      INT   = 16'hFFFF;
      IRQen = 16'hFFFF;
      #1;
      chk("rst_irq", 32'(IRQ), 32'd0);
      chk("rst_irqnum", 32'(IRQnum), 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_hold_irq", 32'(IRQ), 32'd0);
      c = cyc;
      for (int i = 0; i < 16; i++) push(4'(i), c + 4 + 3 * i);
      rst = 1'b1;
      wait_drain("drain_reset_burst", 80);
      INT = '0;
      repeat (5) @(negedge clk);

      // Single line, 2-clk pulse
      IRQen = 16'h0001;
      @(negedge clk);
      c = cyc;
      push(4'd0, c + 4);
      pulse_int(16'h0001, 2);
      wait_drain("drain_single", 20);

      // Priority: lines 5 and 2 together
      IRQen = 16'hFFFF;
      @(negedge clk);
      c = cyc;
      push(4'd2, c + 4);
      push(4'd5, c + 7);
      pulse_int(16'h0024, 2);
      wait_drain("drain_priority", 20);

      // Masking then enable
      IRQen = '0;
      @(negedge clk);
      pulse_int(16'h0002, 2);
      repeat (20) @(negedge clk);
      c = cyc;
      push(4'd1, c + 1);
      IRQen = 16'h0002;
      wait_drain("drain_mask", 20);

      // Merge while masked, then re-arm
      IRQen = '0;
      @(negedge clk);
      pulse_int(16'h0008, 2);
      repeat (2) @(negedge clk);
      pulse_int(16'h0008, 2);
      repeat (6) @(negedge clk);
      c = cyc;
      push(4'd3, c + 1);
      IRQen = 16'h0008;
      wait_drain("drain_merge", 20);
      c = cyc;
      push(4'd3, c + 4);
      pulse_int(16'h0008, 2);
      wait_drain("drain_rearm", 20);

      // Async reset while IRQ is high, with line 9 still pending
      IRQen = 16'hFFFF;
      @(negedge clk);
      INT = 16'h0280;
      repeat (2) @(negedge clk);
      INT = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("pre_rst_irq", 32'(IRQ), 32'd1);
      chk("pre_rst_irqnum", 32'(IRQnum), 32'd7);
      rst = 1'b0;
      #1;
      chk("async_rst_irq", 32'(IRQ), 32'd0);
      chk("async_rst_irqnum", 32'(IRQnum), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (25) @(negedge clk);
      chk("post_rst_quiet", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
